cdc_reg_tx_ctrl: RTL and testbench

//  Source-side sequencer for a w-bit clock-crossing holding register (io_d/io_q/io_en).

---
 rtl/cdc_ctrl_pkg.sv | 16 +
 rtl/cdc_sync_bit.sv | 20 ++
 rtl/cdc_reg_tx_ctrl.sv | 124 ++++++++++++
 tb/tb_cdc_reg_tx_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_ctrl_pkg.sv
// Shared types for the clock-crossing holding-register transmit sequencer.
package cdc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } cdc_tx_state_e;

    localparam int CDC_SYNC_STAGES_DEFAULT = 2;

    function automatic int cdc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Async-reset flop chain bringing a single level signal into the local clock domain.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_reg_tx_ctrl.sv
// Round-robin loader for a clock-crossing holding register with a 2-phase req/ack handshake.
module cdc_reg_tx_ctrl
    import cdc_ctrl_pkg::*;
#(
    parameter  int W           = 15,
    parameter  int N_REQ       = 2,
    parameter  int SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT,
    localparam int IDW         = cdc_idx_w(N_REQ)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_enq_valid,
    output logic [N_REQ-1:0]   o_enq_ready,
    input  logic [N_REQ*W-1:0] i_enq_bits,
    output logic [W-1:0]       o_cdc_d,
    output logic               o_cdc_en,
    output logic [IDW-1:0]     o_cdc_src,
    output logic               o_req_toggle,
    input  logic               i_ack_toggle,
    output logic               o_busy,
    output logic               o_proto_err
);

    cdc_tx_state_e    r_state;
    logic             r_req;
    logic             r_ack_q;
    logic [IDW-1:0]   r_rr;
    logic [IDW-1:0]   r_src;
    logic             r_busy;
    logic             r_perr;

    logic             w_ack_s;
    logic             w_any;
    logic [IDW-1:0]   w_gnt;
    logic [IDW-1:0]   w_rr_nxt;
    logic [W-1:0]     w_gnt_d;
    logic [N_REQ-1:0] w_ready;
    logic             w_load;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk (i_clock),
        .i_rst (i_reset),
        .i_d   (i_ack_toggle),
        .o_q   (w_ack_s)
    );

    // Scan offsets from the highest down so the last hit is the first valid at/after r_rr.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (j == ((int'(r_rr) + k) % N_REQ) && i_enq_valid[j]) begin
                    w_any = 1'b1;
                    w_gnt = IDW'(j);
                end
            end
        end
    end

    assign w_rr_nxt = (int'(w_gnt) == N_REQ - 1) ? '0 : w_gnt + 1'b1;
    assign w_load   = (r_state == IDLE) && w_any;

    always_comb begin
        w_gnt_d = '0;
        w_ready = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_gnt == IDW'(j)) begin
                w_gnt_d    = i_enq_bits[j*W +: W];
                w_ready[j] = w_load;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_ack_q <= 1'b0;
            r_rr    <= '0;
            r_src   <= '0;
            r_busy  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_ack_q <= w_ack_s;
            // Any ack movement outside WAIT means the far side is out of step.
            if ((w_ack_s != r_ack_q) && (r_state != WAIT))
                r_perr <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_src   <= w_gnt;
                        r_rr    <= w_rr_nxt;
                        r_busy  <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_req   <= ~r_req;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_ack_s == r_req) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_enq_ready  = w_ready;
    assign o_cdc_en     = w_load;
    assign o_cdc_d      = w_gnt_d;
    assign o_cdc_src    = r_src;
    assign o_req_toggle = r_req;
    assign o_busy       = r_busy;
    assign o_proto_err  = r_perr;

endmodule

// File: tb/tb_cdc_reg_tx_ctrl.sv
// Randomized bench for cdc_reg_tx_ctrl against a transaction-timeline reference model.
module tb_cdc_reg_tx_ctrl;

    localparam int W    = 15;
    localparam int N    = 2;
    localparam int SYNC = 2;
    localparam int IDW  = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   valid;
    logic [N*W-1:0] bits;
    logic           ack;
    logic [N-1:0]   ready;
    logic [W-1:0]   cdc_d;
    logic           cdc_en;
    logic [IDW-1:0] src;
    logic           req;
    logic           busy;
    logic           perr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cdc_reg_tx_ctrl #(.W(W), .N_REQ(N), .SYNC_STAGES(SYNC)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enq_valid  (valid),
        .o_enq_ready  (ready),
        .i_enq_bits   (bits),
        .o_cdc_d      (cdc_d),
        .o_cdc_en     (cdc_en),
        .o_cdc_src    (src),
        .o_req_toggle (req),
        .i_ack_toggle (ack),
        .o_busy       (busy),
        .o_proto_err  (perr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Far domain: echoes req back on ack after a delay, never exactly on a clock edge.
    bit far_en   = 1'b0;
    bit far_rand = 1'b0;
    int far_dly  = 3;
    int n_echo   = 0;

    initial begin : far_side
        int d;
        forever begin
            @(posedge clk); #1;
            if (far_en && !rst && (req !== ack)) begin
                d = far_rand ? int'($urandom_range(0, 5)) : far_dly;
                repeat (d) @(posedge clk);
                #(1 + (far_rand ? int'($urandom_range(0, 7)) : 0));
                if (far_en && !rst) begin
                    ack = req;
                    n_echo++;
                end
            end
        end
    end

    // Reference model: ack is seen SYNC edges after it is sampled; a transfer accepted in
    // cycle a launches req in a+2 and finishes in the first cycle >= a+2 where seen ack == req.
    logic [SYNC-1:0] m_sync;
    always @(posedge clk or posedge rst) begin
        if (rst) m_sync <= '0;
        else     m_sync <= {m_sync[SYNC-2:0], ack};
    end

    int m_rr, m_src, m_cyc, m_acc_cyc, m_gpend;
    int n_acc = 0, n_reqtog = 0;
    bit m_out, m_freenext, m_accpend, m_req, m_perr, m_perrpend, m_acks_prev;
    int q_gnt[$];

    always @(negedge clk) begin : monitor
        bit in_wait, acks;
        int g, idx;
        logic [N-1:0] vv;
        if (rst) begin
            m_rr = 0; m_src = 0; m_cyc = 0; m_acc_cyc = 0; m_gpend = 0;
            m_out = 0; m_freenext = 0; m_accpend = 0; m_req = 0;
            m_perr = 0; m_perrpend = 0; m_acks_prev = 0;
        end else begin
            m_cyc++;
            if (m_perrpend) m_perr = 1;
            m_perrpend = 0;
            if (m_freenext) begin m_out = 0; m_freenext = 0; end
            if (m_accpend) begin
                m_src = m_gpend; m_rr = (m_gpend + 1) % N;
                m_out = 1; m_acc_cyc = m_cyc - 1; m_accpend = 0;
            end
            if (m_out && m_cyc == m_acc_cyc + 2) begin m_req = !m_req; n_reqtog++; end
            in_wait = m_out && (m_cyc >= m_acc_cyc + 2);
            acks = m_sync[SYNC-1];
            if (acks != m_acks_prev && !in_wait) m_perrpend = 1;
            m_acks_prev = acks;

            chk("busy", 32'(busy), 32'(m_out));
            chk("req_toggle", 32'(req), 32'(m_req));
            chk("cdc_src", 32'(src), 32'(m_src));
            chk("proto_err", 32'(perr), 32'(m_perr));
            chk("no_x", 32'($isunknown({ready, cdc_d, cdc_en, src, req, busy, perr})), 0);

            vv = valid;
            if (!m_out && vv != '0) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && ((vv >> idx) & 1'b1) != '0) g = idx;
                end
                chk("enq_ready", 32'(ready), 32'(1 << g));
                chk("cdc_en", 32'(cdc_en), 1);
                chk("cdc_d", 32'(cdc_d), 32'(W'(bits >> (g * W))));
                m_accpend = 1; m_gpend = g;
                q_gnt.push_back(g);
                n_acc++;
            end else begin
                chk("enq_ready_idle", 32'(ready), 0);
                chk("cdc_en_idle", 32'(cdc_en), 0);
            end
            if (in_wait && acks == m_req) m_freenext = 1;
        end
    end

    task automatic apply_reset();
        @(posedge clk); #3;
        rst = 1'b1; ack = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || (req !== ack)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < 300), 1);
    endtask

    task automatic rand_inputs();
        valid = N'($urandom);
        for (int i = 0; i < N; i++) bits[i*W +: W] = W'($urandom);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, a0, e0, t0;
        bit r0;
        valid = '0; bits = '0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single transfer from requester 0
        @(posedge clk); #1;
        valid = 2'b01; bits[0 +: W] = 15'h1234;
        @(negedge clk);
        chk("t1_ready", 32'(ready), 1);
        chk("t1_en", 32'(cdc_en), 1);
        chk("t1_d", 32'(cdc_d), 32'h1234);
        chk("t1_busy_idle", 32'(busy), 0);
        @(posedge clk); #1 valid = '0;
        @(negedge clk);
        chk("t1_launch_req", 32'(req), 0);
        chk("t1_launch_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_wait_req", 32'(req), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 ack = 1'b1;
        for (int i = 0; i <= SYNC; i++) begin
            @(negedge clk);
            chk("t1_busy_hold", 32'(busy), 1);
        end
        @(negedge clk);
        chk("t1_busy_drop", 32'(busy), 0);

        // Both requesters valid continuously: strict rotation
        apply_reset();
        q_gnt.delete();
        far_rand = 1'b0; far_dly = 3; far_en = 1'b1;
        @(posedge clk); #1 valid = '1;
        repeat (120) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) bits[i*W +: W] = W'($urandom);
        end
        valid = '0;
        repeat (3) @(negedge clk);
        wait_idle("t2_idle_timeout");
        chk("t2_enough_grants", 32'(q_gnt.size() >= 8), 1);
        for (int i = 0; i < 8 && i < q_gnt.size(); i++)
            chk("t2_rotation", 32'(q_gnt[i]), 32'(i % N));

        // Requester 1 held valid with changing payload across WAIT
        a0 = n_acc;
        @(posedge clk); #1 valid = 2'b10;
        repeat (80) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) bits[i*W +: W] = W'($urandom);
        end
        valid = '0;
        repeat (3) @(negedge clk);
        wait_idle("t3_idle_timeout");
        chk("t3_accepts", 32'(n_acc - a0 >= 3), 1);

        // Spurious ack pulse while idle
        far_en = 1'b0;
        r0 = ack;
        @(posedge clk); #1 ack = ~r0;
        @(posedge clk); #1 ack = r0;
        repeat (SYNC + 1) @(negedge clk);
        chk("t4_perr_set", 32'(perr), 1);
        far_en = 1'b1;
        repeat (60) begin @(posedge clk); #1 rand_inputs(); end
        valid = '0;
        repeat (3) @(negedge clk);
        wait_idle("t4_idle_timeout");
        chk("t4_perr_sticky", 32'(perr), 1);

        // Reset asserted while waiting for ack
        far_en = 1'b0;
        r0 = req;
        @(posedge clk); #1 valid = 2'b01;
        @(posedge clk); #1 valid = '0;
        k = 0;
        while (req === r0 && k < 50) begin @(negedge clk); k++; end
        chk("t5_reach_wait", 32'(k < 50), 1);
        @(negedge clk); #2;
        rst = 1'b1; ack = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(ready), 0);
        chk("t5_rst_en", 32'(cdc_en), 0);
        chk("t5_rst_src", 32'(src), 0);
        chk("t5_rst_req", 32'(req), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_perr", 32'(perr), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        far_en = 1'b1;
        a0 = n_acc;
        @(posedge clk); #1 valid = 2'b10; bits[W +: W] = 15'h2bcd;
        @(posedge clk); #1 valid = '0;
        repeat (3) @(negedge clk);
        wait_idle("t5_idle_timeout");
        chk("t5_one_transfer", 32'(n_acc - a0), 1);
        chk("t5_req_after", 32'(req), 1);

        // Random traffic with jittered ack timing
        far_rand = 1'b1;
        a0 = n_acc; e0 = n_echo; t0 = n_reqtog;
        repeat (2000) begin @(posedge clk); #1 rand_inputs(); end
        valid = '0;
        repeat (3) @(negedge clk);
        wait_idle("t6_idle_timeout");
        chk("t6_active", 32'(n_acc - a0 > 20), 1);
        chk("t6_echo_count", 32'(n_echo - e0), 32'(n_acc - a0));
        chk("t6_req_count", 32'(n_reqtog - t0), 32'(n_acc - a0));
        chk("t6_perr_clean", 32'(perr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
